slow_edge_phase_sequencer: RTL and testbench
============================================

Name: slow_edge_phase_sequencer

Overview:
- Fast-clock-domain controller that turns each rising edge of a slow-domain clock into a fixed three-phase pulse sequence: load, compute, writeback.
- Gaps between the phases are programmable.
- Also measures the slow period in fast cycles and flags overruns when a new slow edge arrives before the sequence finishes.
- Sits between the slow-domain clock and the fast-domain datapath enables.

Parameters:
- CNT_W, 8, width of the gap inputs, the internal counters and the period output.
- SYNC_STAGES, 2, number of synchronizer flops on slow_clk_in; legal range is 2 or more.

Ports:
- clk  input  1  fast-domain clock.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is used synchronous to clk.
- slow_clk_in  input  1  raw slow-domain clock or edge signal, asynchronous to clk.
- en  input  1  sequencer enable.
- gap_load  input  CNT_W  extra cycles from edge detect to the load pulse.
- gap_comp  input  CNT_W  extra cycles from the load pulse to the compute pulse.
- gap_wb  input  CNT_W  extra cycles from the compute pulse to the writeback pulse.
- ovr_clr  input  1  clears the overrun flag.
- pulse_load  output  1  one-cycle load strobe.
- pulse_comp  output  1  one-cycle compute strobe.
- pulse_wb  output  1  one-cycle writeback strobe.
- busy  output  1  high when the FSM is not in IDLE.
- period  output  CNT_W  last measured slow period, in fast cycles.
- period_valid  output  1  period holds a real measurement.
- period_sat  output  1  last measurement saturated.
- overrun  output  1  sticky: a slow edge arrived while busy.

Behaviour:
- Reset:
  - All outputs are 0.
  - Synchronizer flops, the delayed copy and all counters are 0.
  - FSM is in IDLE.
  - Reset mid-sequence aborts immediately; no pulse is emitted after rst_n falls.
- Edge detect:
  - slow_clk_in passes through SYNC_STAGES flops to give s.
  - s_d is s delayed by one cycle.
  - edge_det = s & ~s_d, combinational and internal.
  - If slow_clk_in rises and stays stable, edge_det is high for exactly one cycle, SYNC_STAGES cycles after the first clk edge that samples it high.
  - The detect cycle is called cycle E.
- Gap latching: gap_load, gap_comp and gap_wb are registered in cycle E. Changing them mid-sequence has no effect until the next accepted edge.
- FSM states: IDLE, W_LOAD, W_COMP, W_WB. A down-counter gcnt drives the waits.
  - IDLE: on edge_det & en, gcnt <= gap_load and go to W_LOAD.
  - W_LOAD: if gcnt==0, pulse_load=1 for this cycle, gcnt <= gap_comp_latched, go to W_COMP. Otherwise gcnt--.
  - W_COMP: same pattern, pulses pulse_comp, loads gap_wb_latched, goes to W_WB.
  - W_WB: if gcnt==0, pulse_wb=1 and go to IDLE. Otherwise gcnt--.
  - The pulses are registered decodes of the FSM (Moore style), never combinational from inputs.
- Timing:
  - pulse_load in cycle E+1+gap_load.
  - pulse_comp in cycle E+2+gap_load+gap_comp.
  - pulse_wb in cycle E+3+gap_load+gap_comp+gap_wb.
  - The pulses are mutually exclusive.
- busy: high in every cycle from E+1 through the pulse_wb cycle inclusive.
- Enable:
  - en low in IDLE: edges are ignored for sequencing.
  - en falling while busy: the FSM returns to IDLE on the next clk edge, and no further pulses of that sequence are emitted.
  - The period measurement ignores en.
- Overrun:
  - edge_det while the FSM is not in IDLE sets overrun=1. That edge is dropped and the current sequence continues unaffected.
  - edge_det in the same cycle as pulse_wb is also an overrun, since the state is still W_WB.
  - ovr_clr clears overrun on the next cycle.
  - If ovr_clr and a new overrun occur in the same cycle, set wins.
- Period measurement:
  - pcnt increments every cycle and saturates at 2^CNT_W-1.
  - On edge_det, period <= pcnt+1 saturating; period_sat <= 1 if pcnt was at max, else 0; pcnt <= 0.
  - period_valid becomes 1 at the second edge_det after reset and stays 1 until reset.
  - At the first edge_det, period and period_valid are not updated; only pcnt is cleared.
- Width rules: all counters are unsigned CNT_W bits. Gaps of 0 are legal and give back-to-back pulses one cycle apart.

Test Plan:
- Basic sequence. Setup: SYNC_STAGES=2, en=1, gaps 3/0/5, one rising edge on slow_clk_in. Required:
  - pulse_load at E+4, pulse_comp at E+5, pulse_wb at E+11, each one cycle wide.
  - busy high over E+1 to E+11, overrun=0.
- Period. Setup: slow_clk_in toggles every 10 clk cycles (period 20). Required:
  - After the 2nd edge, period=20, period_valid=1, period_sat=0.
  - With CNT_W=4 and the same stimulus, period=15 and period_sat=1.
- Overrun. Setup: gaps 10/10/10, slow edges 16 fast cycles apart. Required:
  - The second edge sets overrun=1 and emits no extra pulses.
  - ovr_clr clears overrun; ovr_clr asserted in the cycle of a new overrun leaves overrun=1.
- Enable abort. Setup: gaps 5/5/5, en dropped 2 cycles after pulse_load. Required:
  - No pulse_comp or pulse_wb.
  - busy=0 by the following cycle.
  - period still updates on the next edge.
- Zero gaps and gap change. Setup: gaps 0/0/0. Required:
  - Pulses at E+1, E+2, E+3.
  - Changing gap_load at E+1 does not alter the current sequence.
- Async reset. Setup: assert rst_n low between pulse_load and pulse_comp. Required:
  - All outputs 0 immediately, with no clk edge needed.
  - After release, the first edge gives period_valid=0.

Source files
------------

// File: rtl/slow_edge_phase_sequencer.sv
// Turns each synchronized rising edge of a slow clock into a load/compute/writeback
// pulse train in the fast domain, and measures the slow period in fast cycles.
//
// state     | meaning
// ----------+-------------------------------------------
// ST_IDLE   | waiting for an accepted slow edge
// ST_W_LOAD | counting down gap_load, then pulse_load
// ST_W_COMP | counting down latched gap_comp, then pulse_comp
// ST_W_WB   | counting down latched gap_wb, then pulse_wb
module slow_edge_phase_sequencer #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_clk_in,
  input  logic             en,
  input  logic [CNT_W-1:0] gap_load,
  input  logic [CNT_W-1:0] gap_comp,
  input  logic [CNT_W-1:0] gap_wb,
  input  logic             ovr_clr,
  output logic             pulse_load,
  output logic             pulse_comp,
  output logic             pulse_wb,
  output logic             busy,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             period_sat,
  output logic             overrun
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_W_LOAD = 2'd1,
    ST_W_COMP = 2'd2,
    ST_W_WB   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_dly_q, s_dly_d;
  logic                   edge_det;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       gcnt_q, gcnt_d;
  logic [CNT_W-1:0]       gap_comp_q, gap_comp_d;
  logic [CNT_W-1:0]       gap_wb_q, gap_wb_d;

  logic                   pulse_load_q, pulse_load_d;
  logic                   pulse_comp_q, pulse_comp_d;
  logic                   pulse_wb_q, pulse_wb_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;

  logic [CNT_W-1:0]       pcnt_q, pcnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   period_valid_q, period_valid_d;
  logic                   period_sat_q, period_sat_d;
  logic                   edge_seen_q, edge_seen_d;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], slow_clk_in};
    s_dly_d  = sync_q[SYNC_STAGES-1];
    edge_det = sync_q[SYNC_STAGES-1] & ~s_dly_q;
  end

  always_comb begin
    state_d    = state_q;
    gcnt_d     = gcnt_q;
    gap_comp_d = gap_comp_q;
    gap_wb_d   = gap_wb_q;

    case (state_q)
      ST_IDLE: begin
        if (edge_det && en) begin
          state_d    = ST_W_LOAD;
          gcnt_d     = gap_load;
          gap_comp_d = gap_comp;
          gap_wb_d   = gap_wb;
        end
      end
      ST_W_LOAD: begin
        if (gcnt_q == CNT_ZERO) begin
          state_d = ST_W_COMP;
          gcnt_d  = gap_comp_q;
        end else begin
          gcnt_d = gcnt_q - CNT_ONE;
        end
      end
      ST_W_COMP: begin
        if (gcnt_q == CNT_ZERO) begin
          state_d = ST_W_WB;
          gcnt_d  = gap_wb_q;
        end else begin
          gcnt_d = gcnt_q - CNT_ONE;
        end
      end
      ST_W_WB: begin
        if (gcnt_q == CNT_ZERO) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Dropping en abandons the running sequence on the next edge.
    if (!en) begin
      state_d = ST_IDLE;
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    pulse_load_d = (state_d == ST_W_LOAD) && (gcnt_d == CNT_ZERO);
    pulse_comp_d = (state_d == ST_W_COMP) && (gcnt_d == CNT_ZERO);
    pulse_wb_d   = (state_d == ST_W_WB)   && (gcnt_d == CNT_ZERO);
    busy_d       = (state_d != ST_IDLE);
  end

  always_comb begin
    overrun_d = overrun_q;
    if (ovr_clr) begin
      overrun_d = 1'b0;
    end
    if (edge_det && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  always_comb begin
    pcnt_d         = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + CNT_ONE;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    period_sat_d   = period_sat_q;
    edge_seen_d    = edge_seen_q;

    if (edge_det) begin
      pcnt_d      = CNT_ZERO;
      edge_seen_d = 1'b1;
      // The first edge after reset only starts the measurement window.
      if (edge_seen_q) begin
        period_d       = (pcnt_q == CNT_MAX) ? CNT_MAX : pcnt_q + CNT_ONE;
        period_sat_d   = (pcnt_q == CNT_MAX);
        period_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q         <= '0;
      s_dly_q        <= 1'b0;
      state_q        <= ST_IDLE;
      gcnt_q         <= '0;
      gap_comp_q     <= '0;
      gap_wb_q       <= '0;
      pulse_load_q   <= 1'b0;
      pulse_comp_q   <= 1'b0;
      pulse_wb_q     <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      pcnt_q         <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      period_sat_q   <= 1'b0;
      edge_seen_q    <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      s_dly_q        <= s_dly_d;
      state_q        <= state_d;
      gcnt_q         <= gcnt_d;
      gap_comp_q     <= gap_comp_d;
      gap_wb_q       <= gap_wb_d;
      pulse_load_q   <= pulse_load_d;
      pulse_comp_q   <= pulse_comp_d;
      pulse_wb_q     <= pulse_wb_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
      pcnt_q         <= pcnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      period_sat_q   <= period_sat_d;
      edge_seen_q    <= edge_seen_d;
    end
  end

  assign pulse_load   = pulse_load_q;
  assign pulse_comp   = pulse_comp_q;
  assign pulse_wb     = pulse_wb_q;
  assign busy         = busy_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign period_sat   = period_sat_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_slow_edge_phase_sequencer.sv
// Directed bench for slow_edge_phase_sequencer: pulse timing, period measurement,
// overrun, enable abort, zero gaps and async reset, with a CNT_W=4 copy for saturation.
module tb_slow_edge_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       slow_clk_in;
  logic       en;
  logic [7:0] gap_load, gap_comp, gap_wb;
  logic       ovr_clr;

  logic       pulse_load, pulse_comp, pulse_wb, busy, period_valid, period_sat, overrun;
  logic [7:0] period;

  logic       pulse_load4, pulse_comp4, pulse_wb4, busy4, period_valid4, period_sat4, overrun4;
  logic [3:0] period4;

  slow_edge_phase_sequencer #(.CNT_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .slow_clk_in(slow_clk_in), .en(en),
    .gap_load(gap_load), .gap_comp(gap_comp), .gap_wb(gap_wb), .ovr_clr(ovr_clr),
    .pulse_load(pulse_load), .pulse_comp(pulse_comp), .pulse_wb(pulse_wb), .busy(busy),
    .period(period), .period_valid(period_valid), .period_sat(period_sat), .overrun(overrun)
  );

  slow_edge_phase_sequencer #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .slow_clk_in(slow_clk_in), .en(en),
    .gap_load(gap_load[3:0]), .gap_comp(gap_comp[3:0]), .gap_wb(gap_wb[3:0]), .ovr_clr(ovr_clr),
    .pulse_load(pulse_load4), .pulse_comp(pulse_comp4), .pulse_wb(pulse_wb4), .busy(busy4),
    .period(period4), .period_valid(period_valid4), .period_sat(period_sat4), .overrun(overrun4)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int n_load, n_comp, n_wb, n_busy, n_multi;
  int t_load, t_comp, t_wb, t_busy0, t_busy1;
  bit seen_busy;

  always @(negedge clk) begin
    if (pulse_load) begin n_load++; t_load = cyc; end
    if (pulse_comp) begin n_comp++; t_comp = cyc; end
    if (pulse_wb)   begin n_wb++;   t_wb   = cyc; end
    if ((int'(pulse_load) + int'(pulse_comp) + int'(pulse_wb)) > 1) n_multi++;
    if (busy) begin
      n_busy++;
      if (!seen_busy) t_busy0 = cyc;
      seen_busy = 1'b1;
      t_busy1 = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    n_load = 0; n_comp = 0; n_wb = 0; n_busy = 0;
    t_load = -1; t_comp = -1; t_wb = -1; t_busy0 = -1; t_busy1 = -1;
    seen_busy = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raised one step after a clk edge; two synchronizer stages put edge_det two cycles later.
  task automatic rise(output int e);
    slow_clk_in = 1'b1;
    e = cyc + 2;
  endtask

  function automatic logic [31:0] flags8();
    return {25'd0, pulse_load, pulse_comp, pulse_wb, busy, period_valid, period_sat, overrun};
  endfunction

  int e, e2, e3, e4, e5, ea, eb;

  initial begin
    n_multi = 0;
    clear_mon();
    rst_n = 1'b0; slow_clk_in = 1'b0; en = 1'b0; ovr_clr = 1'b0;
    gap_load = 8'd0; gap_comp = 8'd0; gap_wb = 8'd0;
    #3;
    chk("reset_flags", flags8(), 32'd0);
    chk("reset_period", {24'd0, period}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Basic sequence, gaps 3/0/5
    gap_load = 8'd3; gap_comp = 8'd0; gap_wb = 8'd5; en = 1'b1;
    clear_mon();
    rise(e);
    tick(20);
    chk("basic_n_load", n_load, 1);
    chk("basic_n_comp", n_comp, 1);
    chk("basic_n_wb", n_wb, 1);
    chk("basic_t_load", t_load - e, 4);
    chk("basic_t_comp", t_comp - e, 5);
    chk("basic_t_wb", t_wb - e, 11);
    chk("basic_busy_first", t_busy0 - e, 1);
    chk("basic_busy_last", t_busy1 - e, 11);
    chk("basic_busy_len", n_busy, 11);
    chk("basic_overrun", overrun, 0);
    slow_clk_in = 1'b0;
    tick(4);

    // Period: slow toggles every 10 cycles
    rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(2);
    rise(ea);
    tick(10); slow_clk_in = 1'b0; tick(10);
    chk("per_first_valid", period_valid, 0);
    chk("per_first_value", period, 0);
    rise(eb);
    tick(5);
    chk("per_gap_check", eb - ea, 20);
    chk("per_value", period, 20);
    chk("per_valid", period_valid, 1);
    chk("per_sat", period_sat, 0);
    chk("per4_value", period4, 15);
    chk("per4_valid", period_valid4, 1);
    chk("per4_sat", period_sat4, 1);
    slow_clk_in = 1'b0;
    tick(10);

    // Overrun: gaps 10/10/10, second edge 16 cycles later
    gap_load = 8'd10; gap_comp = 8'd10; gap_wb = 8'd10;
    clear_mon();
    chk("ovr_pre", overrun, 0);
    rise(e);
    tick(8); slow_clk_in = 1'b0; tick(8);
    rise(e2);
    tick(3);
    chk("ovr_set", overrun, 1);
    tick(35);
    chk("ovr_n_load", n_load, 1);
    chk("ovr_n_comp", n_comp, 1);
    chk("ovr_n_wb", n_wb, 1);
    chk("ovr_t_wb", t_wb - e, 33);
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
    chk("ovr_clear", overrun, 0);
    slow_clk_in = 1'b0;
    tick(3);

    clear_mon();
    rise(e3);
    tick(6); slow_clk_in = 1'b0; tick(2);
    rise(e4);
    tick(3);
    chk("ovr_set2", overrun, 1);
    slow_clk_in = 1'b0;
    tick(3);
    rise(e5);
    tick(2);
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    tick(40);
    slow_clk_in = 1'b0;
    chk("ovr2_n_load", n_load, 1);
    chk("ovr2_n_wb", n_wb, 1);
    chk("ovr2_t_wb", t_wb - e3, 33);
    ovr_clr = 1'b1; tick(1); ovr_clr = 1'b0;
    tick(2);

    // Enable abort: gaps 5/5/5, en dropped 2 cycles after pulse_load
    gap_load = 8'd5; gap_comp = 8'd5; gap_wb = 8'd5; en = 1'b1;
    clear_mon();
    rise(e);
    tick(10);
    en = 1'b0;
    tick(1);
    chk("en_busy_drop", busy, 0);
    slow_clk_in = 1'b0;
    tick(19);
    rise(e2);
    tick(5);
    chk("en_t_load", t_load - e, 6);
    chk("en_n_load", n_load, 1);
    chk("en_n_comp", n_comp, 0);
    chk("en_n_wb", n_wb, 0);
    chk("en_busy_last", t_busy1 - e, 8);
    chk("en_period", period, 30);
    chk("en_idle", busy, 0);
    slow_clk_in = 1'b0; en = 1'b1;
    tick(5);

    // Zero gaps, gaps changed one cycle after the edge
    gap_load = 8'd0; gap_comp = 8'd0; gap_wb = 8'd0;
    clear_mon();
    rise(e);
    tick(3);
    gap_load = 8'd7; gap_comp = 8'd7; gap_wb = 8'd7;
    tick(10);
    chk("zero_t_load", t_load - e, 1);
    chk("zero_t_comp", t_comp - e, 2);
    chk("zero_t_wb", t_wb - e, 3);
    chk("zero_n_wb", n_wb, 1);
    slow_clk_in = 1'b0;
    tick(3);

    // Async reset between pulse_load and pulse_comp
    gap_load = 8'd2; gap_comp = 8'd4; gap_wb = 8'd4;
    clear_mon();
    rise(e);
    tick(7);
    chk("rst_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_flags", flags8(), 32'd0);
    chk("rst_async_period", {24'd0, period}, 32'd0);
    slow_clk_in = 1'b0;
    tick(12);
    chk("rst_n_load", n_load, 1);
    chk("rst_n_comp", n_comp, 0);
    chk("rst_n_wb", n_wb, 0);
    rst_n = 1'b1;
    tick(3);
    clear_mon();
    rise(ea);
    tick(10);
    chk("rst_first_valid", period_valid, 0);
    slow_clk_in = 1'b0;
    tick(15);
    chk("rst_seq_t_wb", t_wb - ea, 13);
    rise(eb);
    tick(4);
    chk("rst_second_valid", period_valid, 1);
    chk("rst_second_period", period, 25);
    chk("mutual_excl", n_multi, 0);
    slow_clk_in = 1'b0;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
